// File: rtl/regfile_wb_arbiter.sv
// Two-requester writeback arbiter (A = ALU, B = load) in front of the single register-bank write port.
// Optional combinational read bypass is enabled with `define REGFILE_WB_BYPASS_EN.
module regfile_wb_arbiter #(
    parameter int unsigned DW       = 32,
    parameter int unsigned AWID     = 5,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            a_valid,
    input  logic [AWID-1:0] a_addr,
    input  logic [DW-1:0]   a_data,
    output logic            a_ready,
    input  logic            b_valid,
    input  logic [AWID-1:0] b_addr,
    input  logic [DW-1:0]   b_data,
    output logic            b_ready,
`ifdef REGFILE_WB_BYPASS_EN
    input  logic [AWID-1:0] ra1,
    input  logic [AWID-1:0] ra2,
    input  logic [DW-1:0]   rd1_in,
    input  logic [DW-1:0]   rd2_in,
    output logic [DW-1:0]   rd1_out,
    output logic [DW-1:0]   rd2_out,
`endif
    output logic            RegWrite,
    output logic [AWID-1:0] AW,
    output logic [DW-1:0]   WriteData,
    output logic            starve_flag
);

    localparam int unsigned CW = 4;
    localparam logic [CW-1:0] WAIT_LIMIT = CW'(MAX_WAIT);

    typedef struct packed {
        logic [AWID-1:0] addr;
        logic [DW-1:0]   data;
    } wb_req_t;

    typedef enum logic [0:0] {
        PRIO_A = 1'b0,
        PRIO_B = 1'b1
    } state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   wait_cnt, wait_cnt_nxt;
    logic            grant_a, grant_b;
    logic            accept;
    wb_req_t         win;

    // State and starvation counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= PRIO_A;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    // B's losing streak; cleared on accept or withdrawal, saturating at the limit
    always_comb begin
        wait_cnt_nxt = wait_cnt;
        if (!b_valid || grant_b) begin
            wait_cnt_nxt = '0;
        end else if (wait_cnt < WAIT_LIMIT) begin
            wait_cnt_nxt = wait_cnt + CW'(1);
        end
    end

    // Next-state: flip to B priority the same edge the counter hits the limit
    always_comb begin
        state_nxt = state;
        case (state)
            PRIO_A: if (wait_cnt_nxt == WAIT_LIMIT) state_nxt = PRIO_B;
            PRIO_B: if (grant_b || !b_valid)        state_nxt = PRIO_A;
            default: state_nxt = PRIO_A;
        endcase
    end

    // Grant outputs; forced low while reset is asserted
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (rst_n) begin
            case (state)
                PRIO_A: begin
                    if (a_valid)      grant_a = 1'b1;
                    else if (b_valid) grant_b = 1'b1;
                end
                PRIO_B: begin
                    if (b_valid)      grant_b = 1'b1;
                    else if (a_valid) grant_a = 1'b1;
                end
                default: begin
                    grant_a = 1'b0;
                    grant_b = 1'b0;
                end
            endcase
        end
    end

    assign a_ready     = grant_a;
    assign b_ready     = grant_b;
    assign starve_flag = (state == PRIO_B);
    assign accept      = grant_a | grant_b;

    always_comb begin
        win = '{addr: a_addr, data: a_data};
        if (grant_b) win = '{addr: b_addr, data: b_data};
    end

    // One-cycle write stage; writes to r0 are acked but never enabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            RegWrite  <= 1'b0;
            AW        <= '0;
            WriteData <= '0;
        end else begin
            RegWrite <= accept && (win.addr != '0);
            if (accept) begin
                AW        <= win.addr;
                WriteData <= win.data;
            end
        end
    end

`ifdef REGFILE_WB_BYPASS_EN
    // Forward the in-flight write to same-cycle readers
    always_comb begin
        rd1_out = rd1_in;
        rd2_out = rd2_in;
        if (RegWrite && (AW != '0) && (AW == ra1)) rd1_out = WriteData;
        if (RegWrite && (AW != '0) && (AW == ra2)) rd2_out = WriteData;
    end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed vector bench for regfile_wb_arbiter: table of per-cycle inputs and expected outputs,
// plus hand-written reset sequences (and bypass checks when REGFILE_WB_BYPASS_EN is defined).
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        a_valid, b_valid;
    logic [4:0]  a_addr, b_addr;
    logic [31:0] a_data, b_data;
    logic        a_ready, b_ready;
    logic        RegWrite;
    logic [4:0]  AW;
    logic [31:0] WriteData;
    logic        starve_flag;
`ifdef REGFILE_WB_BYPASS_EN
    logic [4:0]  ra1, ra2;
    logic [31:0] rd1_in, rd2_in, rd1_out, rd2_out;
`endif

    int n_pass = 0;
    int n_tot  = 0;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.DW(32), .AWID(5), .MAX_WAIT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
`ifdef REGFILE_WB_BYPASS_EN
        .ra1(ra1), .ra2(ra2), .rd1_in(rd1_in), .rd2_in(rd2_in),
        .rd1_out(rd1_out), .rd2_out(rd2_out),
`endif
        .RegWrite(RegWrite), .AW(AW), .WriteData(WriteData), .starve_flag(starve_flag)
    );

    typedef struct {
        logic        av;
        logic [4:0]  aa;
        logic [31:0] ad;
        logic        bv;
        logic [4:0]  ba;
        logic [31:0] bd;
        logic        ear;
        logic        ebr;
        logic        est;
        logic        erw;
        logic [4:0]  eaw;
        logic [31:0] ewd;
        logic        cd;
    } vec_t;

    vec_t tbl[29];

    function automatic vec_t mk(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                                input logic bv, input logic [4:0] ba, input logic [31:0] bd,
                                input logic ear, input logic ebr, input logic est,
                                input logic erw, input logic [4:0] eaw, input logic [31:0] ewd,
                                input logic cd);
        vec_t v;
        v.av = av; v.aa = aa; v.ad = ad; v.bv = bv; v.ba = ba; v.bd = bd;
        v.ear = ear; v.ebr = ebr; v.est = est; v.erw = erw; v.eaw = eaw; v.ewd = ewd; v.cd = cd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else n_pass++;
    endtask

    initial begin
        // Row expectations: readies/starve for this cycle's inputs, write stage from the previous row
        tbl[0]  = mk(0,0,0,             0,0,0,      0,0,0, 0,0,0,             1);
        tbl[1]  = mk(1,8,32'hDEAD_BEEF, 0,0,0,      1,0,0, 0,0,0,             1);
        tbl[2]  = mk(0,0,0,             0,0,0,      0,0,0, 1,8,32'hDEAD_BEEF, 1);
        tbl[3]  = mk(0,0,0,             0,0,0,      0,0,0, 0,8,32'hDEAD_BEEF, 1);
        tbl[4]  = mk(0,0,0,             1,0,5,      0,1,0, 0,8,32'hDEAD_BEEF, 1);
        tbl[5]  = mk(0,0,0,             0,0,0,      0,0,0, 0,0,0,             0);
        tbl[6]  = mk(0,0,0,             0,0,0,      0,0,0, 0,0,0,             0);
        tbl[7]  = mk(1,1,32'h11,        1,9,32'h99, 1,0,0, 0,0,0,             0);
        tbl[8]  = mk(1,1,32'h11,        1,9,32'h99, 1,0,0, 1,1,32'h11,        1);
        tbl[9]  = mk(1,1,32'h11,        1,9,32'h99, 1,0,0, 1,1,32'h11,        1);
        tbl[10] = mk(1,1,32'h11,        1,9,32'h99, 1,0,0, 1,1,32'h11,        1);
        tbl[11] = mk(1,1,32'h11,        1,9,32'h99, 0,1,1, 1,1,32'h11,        1);
        tbl[12] = mk(1,1,32'h11,        1,9,32'h9a, 1,0,0, 1,9,32'h99,        1);
        tbl[13] = mk(0,0,0,             0,0,0,      0,0,0, 1,1,32'h11,        1);
        tbl[14] = mk(0,0,0,             0,0,0,      0,0,0, 0,1,32'h11,        1);
        tbl[15] = mk(1,3,1,             1,3,2,      1,0,0, 0,1,32'h11,        1);
        tbl[16] = mk(0,0,0,             1,3,2,      0,1,0, 1,3,1,             1);
        tbl[17] = mk(0,0,0,             0,0,0,      0,0,0, 1,3,2,             1);
        tbl[18] = mk(0,0,0,             0,0,0,      0,0,0, 0,3,2,             1);
        tbl[19] = mk(1,5,5,             1,6,6,      1,0,0, 0,3,2,             1);
        tbl[20] = mk(1,5,5,             1,6,6,      1,0,0, 1,5,5,             1);
        tbl[21] = mk(1,5,5,             1,6,6,      1,0,0, 1,5,5,             1);
        tbl[22] = mk(0,0,0,             0,0,0,      0,0,0, 1,5,5,             1);
        tbl[23] = mk(1,5,5,             1,6,6,      1,0,0, 0,5,5,             1);
        tbl[24] = mk(1,5,5,             1,6,6,      1,0,0, 1,5,5,             1);
        tbl[25] = mk(1,5,5,             1,6,6,      1,0,0, 1,5,5,             1);
        tbl[26] = mk(1,5,5,             1,6,6,      1,0,0, 1,5,5,             1);
        tbl[27] = mk(1,5,5,             1,6,6,      0,1,1, 1,5,5,             1);
        tbl[28] = mk(0,0,0,             0,0,0,      0,0,0, 1,6,6,             1);

`ifdef REGFILE_WB_BYPASS_EN
        ra1 = '0; ra2 = '0; rd1_in = '0; rd2_in = '0;
`endif
        // Reset held with both requesters asserting
        rst_n   = 1'b0;
        a_valid = 1'b1; a_addr = 5'd8; a_data = 32'h1;
        b_valid = 1'b1; b_addr = 5'd9; b_data = 32'h2;
        repeat (2) @(posedge clk);
        #4;
        chk("rst_a_ready", a_ready, 0);
        chk("rst_b_ready", b_ready, 0);
        chk("rst_regwrite", RegWrite, 0);
        chk("rst_aw", AW, 0);
        chk("rst_writedata", WriteData, 0);
        chk("rst_starve", starve_flag, 0);
        a_valid = 1'b0; b_valid = 1'b0;
        rst_n   = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 29; i++) begin
            a_valid = tbl[i].av; a_addr = tbl[i].aa; a_data = tbl[i].ad;
            b_valid = tbl[i].bv; b_addr = tbl[i].ba; b_data = tbl[i].bd;
            #4;
            chk($sformatf("row%0d_a_ready", i), a_ready, tbl[i].ear);
            chk($sformatf("row%0d_b_ready", i), b_ready, tbl[i].ebr);
            chk($sformatf("row%0d_starve", i), starve_flag, tbl[i].est);
            chk($sformatf("row%0d_regwrite", i), RegWrite, tbl[i].erw);
            if (tbl[i].cd) begin
                chk($sformatf("row%0d_aw", i), AW, tbl[i].eaw);
                chk($sformatf("row%0d_writedata", i), WriteData, tbl[i].ewd);
            end
            @(posedge clk); #1;
        end

        // Write in flight, then asynchronous reset discards it
        a_valid = 1'b1; a_addr = 5'd7; a_data = 32'h77;
        b_valid = 1'b0;
        #4;
        chk("mid_a_ready", a_ready, 1);
        @(posedge clk); #1;
        a_valid = 1'b0;
        chk("mid_regwrite_before", RegWrite, 1);
        chk("mid_aw_before", AW, 7);
`ifdef REGFILE_WB_BYPASS_EN
        ra1 = 5'd7; rd1_in = 32'h0;
        ra2 = 5'd0; rd2_in = 32'h5;
        #1;
        chk("byp_rd1_hit", rd1_out, 32'h77);
        chk("byp_rd2_pass", rd2_out, 32'h5);
        ra2 = 5'd3; rd2_in = 32'h6;
        #1;
        chk("byp_rd2_miss", rd2_out, 32'h6);
`endif
        a_valid = 1'b1;
        rst_n   = 1'b0;
        #1;
        chk("mid_regwrite_rst", RegWrite, 0);
        chk("mid_aw_rst", AW, 0);
        chk("mid_writedata_rst", WriteData, 0);
        chk("mid_a_ready_rst", a_ready, 0);
`ifdef REGFILE_WB_BYPASS_EN
        chk("byp_rd1_after_rst", rd1_out, 32'h0);
`endif
        a_valid = 1'b0;
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_regwrite", RegWrite, 0);
        chk("post_rst_starve", starve_flag, 0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
